// File: rtl/accum_table.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : accum_table
// Purpose  : Per-column accumulator table with saturating or wrapping add,
//            drain reads and sticky per-column overflow flags.
// Revision : 1.0 - initial release
// ============================================================================
module accum_table #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 16,
    parameter int NUM_COLS   = 16,
    parameter int DEPTH      = 1024,
    parameter int SATURATE   = 1,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                           clock_i,
    input  logic                           reset_n_i,
    input  logic                           clear_i,
    input  logic                           wr_en_i,
    input  logic                           wr_first_i,
    input  logic [AW-1:0]                  wr_addr_i,
    input  logic [NUM_COLS*DATA_WIDTH-1:0] wr_data_i,
    input  logic                           rd_en_i,
    input  logic                           rd_clear_i,
    input  logic [AW-1:0]                  rd_addr_i,
    output logic [NUM_COLS*ACC_WIDTH-1:0]  rd_data_o,
    output logic                           rd_valid_o,
    output logic [NUM_COLS-1:0]            ovf_o
);

    localparam int EXT_WIDTH = ACC_WIDTH + 1;

    logic [NUM_COLS*ACC_WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]              valid_q;
    logic [DEPTH-1:0]              valid_d;
    logic [NUM_COLS*ACC_WIDTH-1:0] rd_data_q;
    logic                          rd_valid_q;
    logic [NUM_COLS-1:0]           ovf_q;
    logic [NUM_COLS-1:0]           ovf_d;

    logic                          wr_in_range;
    logic                          rd_in_range;
    logic                          wr_hit;
    logic                          drain_hit;
    logic                          drain_same_row;
    logic                          acc_from_old;
    logic [NUM_COLS*ACC_WIDTH-1:0] old_row;
    logic [NUM_COLS*ACC_WIDTH-1:0] wr_row_d;
    logic [NUM_COLS*ACC_WIDTH-1:0] rd_row;
    logic [NUM_COLS-1:0]           col_ovf;

    // Only a non-power-of-two depth leaves unused address codes to reject.
    generate
        if (DEPTH == (1 << AW)) begin : g_pow2
            assign wr_in_range = 1'b1;
            assign rd_in_range = 1'b1;
        end else begin : g_npow2
            assign wr_in_range = (32'(wr_addr_i) < 32'(DEPTH));
            assign rd_in_range = (32'(rd_addr_i) < 32'(DEPTH));
        end
    endgenerate

    assign wr_hit         = wr_en_i && wr_in_range && !clear_i;
    assign drain_hit      = rd_en_i && rd_clear_i && rd_in_range;
    assign drain_same_row = drain_hit && (rd_addr_i == wr_addr_i);
    // A same-cycle drain of the target row empties it before the write lands.
    assign acc_from_old   = valid_q[wr_addr_i] && !wr_first_i && !drain_same_row;
    assign old_row        = mem_q[wr_addr_i];
    assign rd_row         = (rd_in_range && valid_q[rd_addr_i]) ? mem_q[rd_addr_i] : '0;

    generate
        for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
            logic signed [ACC_WIDTH-1:0]  old_acc;
            logic signed [DATA_WIDTH-1:0] din;
            logic signed [EXT_WIDTH-1:0]  sum;
            logic [ACC_WIDTH-1:0]         sat_val;

            assign old_acc    = acc_from_old ? old_row[c*ACC_WIDTH +: ACC_WIDTH] : '0;
            assign din        = wr_data_i[c*DATA_WIDTH +: DATA_WIDTH];
            assign sum        = EXT_WIDTH'(old_acc) + EXT_WIDTH'(din);
            assign col_ovf[c] = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
            assign sat_val    = sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                               : {1'b0, {(ACC_WIDTH-1){1'b1}}};
            assign wr_row_d[c*ACC_WIDTH +: ACC_WIDTH] =
                ((SATURATE != 0) && col_ovf[c]) ? sat_val : sum[ACC_WIDTH-1:0];
        end
    endgenerate

    // Row storage carries no reset; the valid bits mask stale contents.
    always_ff @(posedge clock_i) begin
        if (wr_hit) begin
            mem_q[wr_addr_i] <= wr_row_d;
        end
    end

    always_comb begin
        valid_d = valid_q;
        ovf_d   = ovf_q;
        if (clear_i) begin
            valid_d = '0;
            ovf_d   = '0;
        end else begin
            if (drain_hit) begin
                valid_d[rd_addr_i] = 1'b0;
            end
            if (wr_hit) begin
                valid_d[wr_addr_i] = 1'b1;
                ovf_d              = ovf_q | col_ovf;
            end
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            valid_q    <= '0;
            ovf_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            ovf_q      <= ovf_d;
            rd_valid_q <= rd_en_i;
            if (rd_en_i) begin
                rd_data_q <= rd_row;
            end
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign ovf_o      = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_accum_table.sv
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_accum_table
// Purpose  : Self-checking bench for accum_table, saturating and wrapping
//            instances driven in parallel against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_accum_table;

    localparam int DW    = 8;
    localparam int ACC   = 10;
    localparam int NC    = 4;
    localparam int DEPTH = 12;
    localparam int AW    = 4;
    localparam int MAXV  = (1 << (ACC - 1)) - 1;
    localparam int MINV  = -(1 << (ACC - 1));
    localparam int SPAN  = 1 << ACC;

    logic           clk      = 1'b0;
    logic           rst_n    = 1'b1;
    logic           clear    = 1'b0;
    logic           wr_en    = 1'b0;
    logic           wr_first = 1'b0;
    logic           rd_en    = 1'b0;
    logic           rd_clear = 1'b0;
    logic [AW-1:0]  wr_addr  = '0;
    logic [AW-1:0]  rd_addr  = '0;
    logic [NC*DW-1:0] wr_data = '0;

    logic [NC*ACC-1:0] rd_data_s, rd_data_w;
    logic              rd_valid_s, rd_valid_w;
    logic [NC-1:0]     ovf_s, ovf_w;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: index 0 = saturating instance, 1 = wrapping instance.
    int m_val   [2][16][NC];
    bit m_valid [16];
    int e_data  [2][NC];
    bit e_rv;
    bit e_ovf   [2][NC];

    always #5 clk = ~clk;

    accum_table #(
        .DATA_WIDTH(DW), .ACC_WIDTH(ACC), .NUM_COLS(NC), .DEPTH(DEPTH), .SATURATE(1)
    ) u_sat (
        .clock_i(clk), .reset_n_i(rst_n), .clear_i(clear),
        .wr_en_i(wr_en), .wr_first_i(wr_first), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .rd_en_i(rd_en), .rd_clear_i(rd_clear), .rd_addr_i(rd_addr),
        .rd_data_o(rd_data_s), .rd_valid_o(rd_valid_s), .ovf_o(ovf_s)
    );

    accum_table #(
        .DATA_WIDTH(DW), .ACC_WIDTH(ACC), .NUM_COLS(NC), .DEPTH(DEPTH), .SATURATE(0)
    ) u_wrap (
        .clock_i(clk), .reset_n_i(rst_n), .clear_i(clear),
        .wr_en_i(wr_en), .wr_first_i(wr_first), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .rd_en_i(rd_en), .rd_clear_i(rd_clear), .rd_addr_i(rd_addr),
        .rd_data_o(rd_data_w), .rd_valid_o(rd_valid_w), .ovf_o(ovf_w)
    );

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic int dut_col(input int inst, input int c);
        logic signed [ACC-1:0] s;
        s = (inst == 0) ? rd_data_s[c*ACC +: ACC] : rd_data_w[c*ACC +: ACC];
        return int'(s);
    endfunction

    function automatic int dut_rv(input int inst);
        return (inst == 0) ? int'(rd_valid_s) : int'(rd_valid_w);
    endfunction

    function automatic int dut_ovf(input int inst, input int c);
        return (inst == 0) ? int'(ovf_s[c]) : int'(ovf_w[c]);
    endfunction

    function automatic int accum(input int base, input int d, input bit sat, output bit o);
        int s;
        s = base + d;
        o = 1'b0;
        if (s > MAXV || s < MINV) begin
            o = 1'b1;
            if (sat) s = (s > MAXV) ? MAXV : MINV;
            else     s = (s > MAXV) ? s - SPAN : s + SPAN;
        end
        return s;
    endfunction

    function automatic void model_reset();
        for (int r = 0; r < 16; r++) m_valid[r] = 1'b0;
        for (int i = 0; i < 2; i++)
            for (int c = 0; c < NC; c++) begin
                e_data[i][c] = 0;
                e_ovf[i][c]  = 1'b0;
            end
        e_rv = 1'b0;
    endfunction

    // One clock edge of the table, applied in the order the rules describe:
    // read sees old contents, clear wins, drain empties before the write lands.
    function automatic void model_step();
        int  ra, wa, base;
        byte d;
        bit  o;
        ra   = int'(rd_addr);
        wa   = int'(wr_addr);
        e_rv = rd_en;
        if (rd_en)
            for (int i = 0; i < 2; i++)
                for (int c = 0; c < NC; c++)
                    e_data[i][c] = (ra < DEPTH && m_valid[ra]) ? m_val[i][ra][c] : 0;
        if (clear) begin
            for (int r = 0; r < 16; r++) m_valid[r] = 1'b0;
            for (int i = 0; i < 2; i++)
                for (int c = 0; c < NC; c++) e_ovf[i][c] = 1'b0;
        end else begin
            if (rd_en && rd_clear && ra < DEPTH) m_valid[ra] = 1'b0;
            if (wr_en && wa < DEPTH) begin
                for (int i = 0; i < 2; i++)
                    for (int c = 0; c < NC; c++) begin
                        d    = wr_data[c*DW +: DW];
                        base = (m_valid[wa] && !wr_first) ? m_val[i][wa][c] : 0;
                        m_val[i][wa][c] = accum(base, int'(d), (i == 0), o);
                        if (o) e_ovf[i][c] = 1'b1;
                    end
                m_valid[wa] = 1'b1;
            end
        end
    endfunction

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rd_valid[%0d]", i), dut_rv(i), int'(e_rv));
            for (int c = 0; c < NC; c++) begin
                chk($sformatf("rd_data[%0d][%0d]", i, c), dut_col(i, c), e_data[i][c]);
                chk($sformatf("ovf[%0d][%0d]", i, c), dut_ovf(i, c), int'(e_ovf[i][c]));
            end
        end
    endtask

    always @(negedge rst_n) model_reset();

    always @(posedge clk) begin
        if (rst_n) model_step();
        #1;
        compare_all();
    end

    task automatic idle();
        wr_en = 1'b0; wr_first = 1'b0; rd_en = 1'b0; rd_clear = 1'b0; clear = 1'b0;
    endtask

    task automatic set_all(input int v);
        for (int c = 0; c < NC; c++) wr_data[c*DW +: DW] = DW'(v);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic write(input int a, input int v, input bit first);
        idle(); wr_en = 1'b1; wr_first = first; wr_addr = AW'(a); set_all(v); tick();
    endtask

    task automatic read(input int a, input bit drain);
        idle(); rd_en = 1'b1; rd_clear = drain; rd_addr = AW'(a); tick();
    endtask

    task automatic expect_row(input string name, input int exp_sat, input int exp_wrap);
        chk({name, ".valid_sat"}, int'(rd_valid_s), 1);
        chk({name, ".valid_wrap"}, int'(rd_valid_w), 1);
        for (int c = 0; c < NC; c++) begin
            chk($sformatf("%s.sat%0d", name, c), dut_col(0, c), exp_sat);
            chk($sformatf("%s.wrap%0d", name, c), dut_col(1, c), exp_wrap);
        end
    endtask

    task automatic expect_zero_outputs(input string name);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s.rv%0d", name, i), dut_rv(i), 0);
            for (int c = 0; c < NC; c++) begin
                chk($sformatf("%s.data%0d_%0d", name, i, c), dut_col(i, c), 0);
                chk($sformatf("%s.ovf%0d_%0d", name, i, c), dut_ovf(i, c), 0);
            end
        end
    endtask

    task automatic pulse_reset(input string name);
        #2 rst_n = 1'b0;
        #0.5;
        expect_zero_outputs(name);
        #0.5 rst_n = 1'b1;
    endtask

    initial begin
        int v;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        expect_zero_outputs("reset");
        rst_n = 1'b1;

        for (int r = 0; r < 8; r++) begin
            read(r, 1'b0);
            expect_row($sformatf("empty_row%0d", r), 0, 0);
        end

        repeat (4) write(3, 5, 1'b0);
        read(3, 1'b0);
        expect_row("accum4x5", 20, 20);

        repeat (5) write(0, 127, 1'b0);
        read(0, 1'b0);
        expect_row("ovf_row0", 511, -389);
        chk("ovf_sat_flags", int'(ovf_s), 15);
        chk("ovf_wrap_flags", int'(ovf_w), 15);

        write(2, 9, 1'b1);
        idle(); rd_en = 1'b1; rd_clear = 1'b1; rd_addr = AW'(2);
        wr_en = 1'b1; wr_addr = AW'(2); set_all(4); tick();
        expect_row("drain_and_write", 9, 9);
        read(2, 1'b0);
        expect_row("after_drain_write", 4, 4);
        read(2, 1'b1);
        expect_row("drain_only", 4, 4);
        read(2, 1'b0);
        expect_row("after_drain", 0, 0);

        write(1, 7, 1'b1);
        write(1, -3, 1'b1);
        read(1, 1'b0);
        expect_row("wr_first", -3, -3);
        idle(); clear = 1'b1; wr_en = 1'b1; wr_addr = AW'(1); set_all(6); tick();
        read(1, 1'b0);
        expect_row("after_clear", 0, 0);
        chk("ovf_sat_cleared", int'(ovf_s), 0);
        chk("ovf_wrap_cleared", int'(ovf_w), 0);

        write(4, 11, 1'b1);
        idle(); clear = 1'b1; rd_en = 1'b1; rd_addr = AW'(4); tick();
        expect_row("read_during_clear", 11, 11);
        read(4, 1'b0);
        expect_row("read_after_clear", 0, 0);

        write(13, 50, 1'b0);
        read(13, 1'b0);
        expect_row("out_of_range", 0, 0);

        for (int k = 0; k < 1500; k++) begin
            idle();
            wr_en    = ($urandom_range(0, 9) < 6);
            wr_first = ($urandom_range(0, 9) == 0);
            wr_addr  = AW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3));
            for (int c = 0; c < NC; c++) begin
                v = $urandom_range(0, 1) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 20)) - 10;
                wr_data[c*DW +: DW] = DW'(v);
            end
            rd_en    = $urandom_range(0, 1);
            rd_clear = ($urandom_range(0, 4) == 0);
            rd_addr  = AW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3));
            clear    = ($urandom_range(0, 99) == 0);
            if (k == 700) pulse_reset("reset_random");
            tick();
        end

        for (int r = 0; r < 3; r++) write(r, 100, 1'b0);
        write(0, 100, 1'b0);
        idle();
        pulse_reset("reset_midstream");
        tick();
        for (int r = 0; r < 16; r++) begin
            read(r, 1'b0);
            expect_row($sformatf("post_reset_row%0d", r), 0, 0);
        end
        idle();
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/accum_table.md
ACCUM_TABLE -- requirements
Module: accum_table

Interface
REQ-001 Parameter DATA_WIDTH, default 8: bits per input element, two's complement.
REQ-002 Parameter ACC_WIDTH, default 16: bits per accumulator entry, ACC_WIDTH >= DATA_WIDTH.
REQ-003 Parameter NUM_COLS, default 16: independent accumulator channels, one per systolic-array column.
REQ-004 Parameter DEPTH, default 1024: rows per channel; AW = $clog2(DEPTH).
REQ-005 Parameter SATURATE, default 1: 1 = clamp on overflow, 0 = wrap modulo 2^ACC_WIDTH.
REQ-006 clock  in  1  single clock; all state updates on the rising edge.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 clear  in  1  synchronous clear of all rows and all overflow flags.
REQ-009 wr_en  in  1  accumulate wr_data into row wr_addr.
REQ-010 wr_first  in  1  with wr_en, overwrite row with sign-extended wr_data instead of accumulating.
REQ-011 wr_addr  in  AW  write row.
REQ-012 wr_data  in  NUM_COLS*DATA_WIDTH  channel c in bits [c*DATA_WIDTH +: DATA_WIDTH].
REQ-013 rd_en  in  1  read row rd_addr.
REQ-014 rd_clear  in  1  with rd_en, read the row and then empty it (drain mode).
REQ-015 rd_addr  in  AW  read row.
REQ-016 rd_data  out  NUM_COLS*ACC_WIDTH  registered read data, channel c in [c*ACC_WIDTH +: ACC_WIDTH].
REQ-017 rd_valid  out  1  high for the one cycle in which rd_data holds a read result.
REQ-018 ovf  out  NUM_COLS  sticky per-channel overflow flags.

Function
REQ-019 Each row SHALL have a valid bit; a row whose valid bit is 0 SHALL read as 0 and accumulate from 0.
REQ-020 On a wr_en cycle, each channel SHALL compute new = (row valid and not wr_first ? old : 0) + sign_extend(wr_data[c]) at ACC_WIDTH+1 bits, then write the result and set the valid bit at the same edge.
REQ-021 Write throughput SHALL be one row per cycle; back-to-back writes to the same address SHALL accumulate both values, with no lost update.
REQ-022 On overflow with SATURATE=1, the SHALL clamp the result to +(2^(ACC_WIDTH-1))-1 or -(2^(ACC_WIDTH-1)); with SATURATE=0 the result SHALL wrap; in either mode ovf[c] SHALL be set.
REQ-023 Read latency SHALL be one cycle: rd_data and rd_valid update at the edge following the rd_en cycle.
REQ-024 rd_data SHALL hold its last value when rd_valid is low.
REQ-025 When rd_en and wr_en target the same address in the same cycle, the read SHALL return the pre-write value.
REQ-026 rd_en with rd_clear SHALL clear the valid bit of rd_addr at the same edge at which the data is captured.
REQ-027 When rd_clear and wr_en hit the same address in the same cycle, the clear SHALL apply first: the row SHALL end valid and equal to sign_extend(wr_data).
REQ-028 clear SHALL zero all valid bits and ovf in one cycle and SHALL take priority over a write in the same cycle, with that write discarded; a read in that cycle SHALL still return the pre-clear contents.
REQ-029 Address wrap: addresses >= DEPTH (possible only for non-power-of-two DEPTH) SHALL be ignored for writes and SHALL read as 0.
REQ-030 The row storage itself SHALL NOT require reset; only valid bits, rd_data, rd_valid and ovf are reset.

Reset
REQ-031 While reset_n is low: all valid bits = 0, rd_data = 0, rd_valid = 0, ovf = 0, asynchronously.
REQ-032 Assertion of reset_n mid-operation SHALL abort any in-flight read (rd_valid = 0), and a write in that cycle SHALL have no effect.
REQ-033 After reset_n deasserts, the first edge SHALL accept rd_en and wr_en normally.

Verification
REQ-034 Reset, then rd_en at rows 0..7 -> rd_valid pulses and rd_data = 0 in all channels, ovf = 0.
REQ-035 Write to row 3, all channels 5, for 4 consecutive cycles, then read row 3 -> every channel reads 20, one cycle after rd_en.
REQ-036 DATA_WIDTH=8, ACC_WIDTH=10, SATURATE=1: write 127 five times to row 0 -> reads 511, ovf all ones; with SATURATE=0 -> reads 635-1024 = -389, ovf set.
REQ-037 Row 2 holds 9; in the same cycle rd_en+rd_clear at row 2 and wr_en of 4 at row 2 -> read returns 9, next read returns 4; a drain-read without the write -> next read returns 0.
REQ-038 Row 1 holds 7; wr_first with -3 -> reads -3; clear asserted together with wr_en of 6 at row 1 -> subsequent read returns 0, ovf = 0.
REQ-039 Drop reset_n low for 1 ns mid-stream during accumulation -> outputs are immediately 0, all rows read 0 afterwards.
